jtag_debug_host_shifter: RTL and testbench

Host-side virtual-JTAG initiator for the CPU on-chip debug module. It accepts one {IR, DR} command and drives the virtual-JTAG strobe set (UIR, CDR, SDR, UDR) plus a divided TCK and serial TDI into the debug module's TCK-domain logic. It captures the TDO stream and returns the scanned-out DR word. It sits between a system-side debug master (or test harness) and the debug module's `ir_in`/`tck`/`tdi`/`tdo`/`vs_*` pins, replacing the physical JTAG hub when the hub is absent.

---
 rtl/jtag_debug_host_shifter.sv | 210 +++++++++++++++++++++
 tb/tb_jtag_debug_host_shifter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_host_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_debug_host_shifter
//  Description : Host-side virtual-JTAG initiator. Accepts one {IR, DR}
//                command, walks the virtual-state strobes UIR -> CDR ->
//                SDR x DR_WIDTH -> UDR around a divided scan clock, shifts
//                the DR out LSB first on tdi, gathers tdo, and returns the
//                captured word on a valid/ready response channel.
//  Ports       : clk, reset          - system clock, synchronous active-high reset
//                cmd_valid/cmd_ready - command handshake (ready only in IDLE)
//                cmd_ir, cmd_dr      - virtual IR and DR to scan in
//                rsp_valid/rsp_ready - response handshake
//                rsp_dr              - captured TDO word, bit 0 first sampled
//                tck, tdi, tdo       - scan clock and serial data
//                ir_in               - latched virtual IR for the target
//                vs_uir/cdr/sdr/udr  - virtual-state strobes
//                jtag_state_rti      - high while idle or holding a response
//  Revision    : 1.0  initial release
// ============================================================================
module jtag_debug_host_shifter #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_HALF = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int PH_W  = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

    localparam logic [PH_W-1:0]  c_PH_LAST  = PH_W'(TCK_HALF - 1);
    localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(DR_WIDTH - 1);

    // LOAD is a single-cycle launch state between acceptance and UIR; it
    // places the first UIR cycle one clock after the accepting edge.
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LOAD = 3'd1;
    localparam logic [2:0] c_ST_UIR  = 3'd2;
    localparam logic [2:0] c_ST_CDR  = 3'd3;
    localparam logic [2:0] c_ST_SDR  = 3'd4;
    localparam logic [2:0] c_ST_UDR  = 3'd5;
    localparam logic [2:0] c_ST_RSP  = 3'd6;

    logic [2:0]          state_q,  state_d;
    logic [PH_W-1:0]     phase_q,  phase_d;
    logic                tck_q,    tck_d;
    logic [BIT_W-1:0]    bit_q,    bit_d;
    logic [DR_WIDTH-1:0] shreg_q,  shreg_d;
    logic [DR_WIDTH-1:0] cap_q,    cap_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic [IR_WIDTH-1:0] ir_q,     ir_d;

    logic cmd_ready_q;
    logic rsp_valid_q;
    logic tdi_q;
    logic rti_q;
    logic uir_q, cdr_q, sdr_q, udr_q;

    logic w_accept;
    logic w_scan;
    logic w_tick;
    logic w_rise;
    logic w_fall;

    assign w_accept = (state_q == c_ST_IDLE) && cmd_valid && cmd_ready_q;
    assign w_scan   = (state_q == c_ST_UIR) || (state_q == c_ST_CDR) ||
                      (state_q == c_ST_SDR) || (state_q == c_ST_UDR);
    // tck toggles when the phase counter wraps; the wrap with tck high is
    // the end of a TCK period and is the only point the FSM may advance.
    assign w_tick   = w_scan && (phase_q == c_PH_LAST);
    assign w_rise   = w_tick && !tck_q;
    assign w_fall   = w_tick &&  tck_q;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        tck_d    = tck_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        cap_d    = cap_q;
        rsp_dr_d = rsp_dr_q;
        ir_d     = ir_q;

        if (w_scan) begin
            phase_d = w_tick ? '0 : phase_q + 1'b1;
            tck_d   = tck_q ^ w_tick;
        end

        case (state_q)
            c_ST_IDLE: begin
                phase_d = '0;
                tck_d   = 1'b0;
                if (w_accept) begin
                    ir_d    = cmd_ir;
                    shreg_d = cmd_dr;
                    state_d = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                phase_d = '0;
                tck_d   = 1'b0;
                bit_d   = '0;
                state_d = c_ST_UIR;
            end
            c_ST_UIR: begin
                if (w_fall) state_d = c_ST_CDR;
            end
            c_ST_CDR: begin
                if (w_fall) begin
                    bit_d   = '0;
                    state_d = c_ST_SDR;
                end
            end
            c_ST_SDR: begin
                // Shifting capture in from the top leaves the first sampled
                // bit at position 0 after DR_WIDTH samples.
                if (w_rise) cap_d = {tdo, cap_q[DR_WIDTH-1:1]};
                if (w_fall) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == c_BIT_LAST) begin
                        rsp_dr_d = cap_q;
                        state_d  = c_ST_UDR;
                    end
                end
            end
            c_ST_UDR: begin
                if (w_fall) state_d = c_ST_RSP;
            end
            c_ST_RSP: begin
                tck_d = 1'b0;
                if (rsp_ready) state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= c_ST_IDLE;
            phase_q     <= '0;
            tck_q       <= 1'b0;
            bit_q       <= '0;
            shreg_q     <= '0;
            cap_q       <= '0;
            rsp_dr_q    <= '0;
            ir_q        <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            tdi_q       <= 1'b0;
            rti_q       <= 1'b1;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tck_q       <= tck_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            cap_q       <= cap_d;
            rsp_dr_q    <= rsp_dr_d;
            ir_q        <= ir_d;
            // Ready returns one cycle after re-entering IDLE and drops on
            // the accepting edge so a held cmd_valid is taken only once.
            cmd_ready_q <= (state_q == c_ST_IDLE) && !w_accept;
            rsp_valid_q <= (state_d == c_ST_RSP);
            tdi_q       <= (state_d == c_ST_SDR) && shreg_d[0];
            rti_q       <= (state_d == c_ST_IDLE) || (state_d == c_ST_RSP);
            uir_q       <= (state_d == c_ST_UIR);
            cdr_q       <= (state_d == c_ST_CDR);
            sdr_q       <= (state_d == c_ST_SDR);
            udr_q       <= (state_d == c_ST_UDR);
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_dr         = rsp_dr_q;
    assign tck            = tck_q;
    assign tdi            = tdi_q;
    assign ir_in          = ir_q;
    assign vs_uir         = uir_q;
    assign vs_cdr         = cdr_q;
    assign vs_sdr         = sdr_q;
    assign vs_udr         = udr_q;
    assign jtag_state_rti = rti_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_debug_host_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_debug_host_shifter
//  Description : Bench for jtag_debug_host_shifter. Two instances: dut 0
//                with TCK_HALF=2 and dut 1 with TCK_HALF=1. A timing model
//                derives every output from the cycle count since acceptance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jtag_debug_host_shifter;

    localparam int DRW = 38;
    localparam int IRW = 2;
    localparam int M_RDY  = 0;
    localparam int M_WAIT = 1;
    localparam int M_SCAN = 2;
    localparam int M_RSP  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic           cmd_valid_a [2];
    logic           cmd_ready_a [2];
    logic [IRW-1:0] cmd_ir_a    [2];
    logic [DRW-1:0] cmd_dr_a    [2];
    logic           rsp_valid_a [2];
    logic           rsp_ready_a [2];
    logic [DRW-1:0] rsp_dr_a    [2];
    logic           tck_a       [2];
    logic           tdi_a       [2];
    logic           tdo_a       [2];
    logic [IRW-1:0] ir_in_a     [2];
    logic           uir_a       [2];
    logic           cdr_a       [2];
    logic           sdr_a       [2];
    logic           udr_a       [2];
    logic           rti_a       [2];
    logic           loop_a      [2];
    logic           const_a     [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic armed = 1'b0;

    // model state per instance
    int             mode_m [2] = '{M_RDY, M_RDY};
    int             e_m    [2] = '{0, 0};
    logic [IRW-1:0] ir_m   [2] = '{2'b00, 2'b00};
    logic [DRW-1:0] dr_m   [2] = '{'0, '0};
    logic [DRW-1:0] cap_m  [2] = '{'0, '0};
    logic [DRW-1:0] rsp_m  [2] = '{'0, '0};

    // monitor counters
    logic prev_tck0 = 1'b0;
    logic prev_tck1 = 1'b0;
    logic prev_scan1 = 1'b0;
    int n_uir = 0, n_uir_r = 0, n_cdr = 0, n_cdr_r = 0, n_udr = 0, n_udr_r = 0;
    int n_sdr_r = 0, n_tdi_sdr = 0, n_ir_bad = 0, n_rv0 = 0;
    int n1_pairs = 0, n1_same = 0;

    always #5 clk = ~clk;

    assign tdo_a[0] = loop_a[0] ? tdi_a[0] : const_a[0];
    assign tdo_a[1] = loop_a[1] ? tdi_a[1] : const_a[1];

    jtag_debug_host_shifter #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(2)) dut0 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_a[0]), .cmd_ready(cmd_ready_a[0]),
        .cmd_ir(cmd_ir_a[0]), .cmd_dr(cmd_dr_a[0]),
        .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]), .rsp_dr(rsp_dr_a[0]),
        .tck(tck_a[0]), .tdi(tdi_a[0]), .tdo(tdo_a[0]), .ir_in(ir_in_a[0]),
        .vs_uir(uir_a[0]), .vs_cdr(cdr_a[0]), .vs_sdr(sdr_a[0]), .vs_udr(udr_a[0]),
        .jtag_state_rti(rti_a[0])
    );

    jtag_debug_host_shifter #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_HALF(1)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_a[1]), .cmd_ready(cmd_ready_a[1]),
        .cmd_ir(cmd_ir_a[1]), .cmd_dr(cmd_dr_a[1]),
        .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]), .rsp_dr(rsp_dr_a[1]),
        .tck(tck_a[1]), .tdi(tdi_a[1]), .tdo(tdo_a[1]), .ir_in(ir_in_a[1]),
        .vs_uir(uir_a[1]), .vs_cdr(cdr_a[1]), .vs_sdr(sdr_a[1]), .vs_udr(udr_a[1]),
        .jtag_state_rti(rti_a[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int th_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Expected {cmd_ready, rti, rsp_valid, tck, tdi, uir, cdr, sdr, udr}.
    // During a scan, cycle e after acceptance (e>=1) lies in period (e-1)/P
    // at phase (e-1)%P; period 0 is UIR, 1 is CDR, 2..DRW+1 shift DR bit
    // (period-2), period DRW+2 is UDR. tck is high in the second half.
    function automatic logic [8:0] exp_vec(input int mode, input int e, input int th,
                                           input logic [DRW-1:0] dr);
        int p;
        int u;
        int per;
        logic [8:0] v;
        p = 2 * th;
        v = '0;
        case (mode)
            M_RDY:  begin v[8] = 1'b1; v[7] = 1'b1; end
            M_WAIT: v[7] = 1'b1;
            M_RSP:  begin v[7] = 1'b1; v[6] = 1'b1; end
            default: begin
                if (e >= 1) begin
                    u    = e - 1;
                    per  = u / p;
                    v[5] = ((u % p) >= th);
                    if (per == 0) v[3] = 1'b1;
                    else if (per == 1) v[2] = 1'b1;
                    else if (per <= DRW + 1) begin
                        v[1] = 1'b1;
                        v[4] = dr[per-2];
                    end else v[0] = 1'b1;
                end
            end
        endcase
        return v;
    endfunction

    // Model: advances on every rising edge using the inputs held that cycle.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) armed = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                mode_m[d] = M_RDY;
                e_m[d]    = 0;
                ir_m[d]   = '0;
                rsp_m[d]  = '0;
            end else begin
                case (mode_m[d])
                    M_RDY: if (cmd_valid_a[d]) begin
                        mode_m[d] = M_SCAN;
                        e_m[d]    = 0;
                        ir_m[d]   = cmd_ir_a[d];
                        dr_m[d]   = cmd_dr_a[d];
                        cap_m[d]  = loop_a[d] ? cmd_dr_a[d] : {DRW{const_a[d]}};
                    end
                    M_WAIT: mode_m[d] = M_RDY;
                    M_SCAN: begin
                        e_m[d]++;
                        if (e_m[d] == 1 + (DRW + 2) * 2 * th_of(d)) rsp_m[d] = cap_m[d];
                        if (e_m[d] == 1 + (DRW + 3) * 2 * th_of(d)) mode_m[d] = M_RSP;
                    end
                    default: if (rsp_ready_a[d]) mode_m[d] = M_WAIT;
                endcase
            end
        end
    end

    // Compare process plus event counters, on the falling edge.
    initial forever begin
        @(negedge clk);
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                chk((d == 0) ? "dut0 outputs" : "dut1 outputs",
                    64'({cmd_ready_a[d], rti_a[d], rsp_valid_a[d], tck_a[d], tdi_a[d],
                         uir_a[d], cdr_a[d], sdr_a[d], udr_a[d]}),
                    64'(exp_vec(mode_m[d], e_m[d], th_of(d), dr_m[d])));
                chk((d == 0) ? "dut0 ir_in" : "dut1 ir_in", 64'(ir_in_a[d]), 64'(ir_m[d]));
                chk((d == 0) ? "dut0 rsp_dr" : "dut1 rsp_dr", 64'(rsp_dr_a[d]), 64'(rsp_m[d]));
            end
        end
        n_uir     += int'(uir_a[0]);
        n_uir_r   += int'(uir_a[0] & tck_a[0] & ~prev_tck0);
        n_cdr     += int'(cdr_a[0]);
        n_cdr_r   += int'(cdr_a[0] & tck_a[0] & ~prev_tck0);
        n_udr     += int'(udr_a[0]);
        n_udr_r   += int'(udr_a[0] & tck_a[0] & ~prev_tck0);
        n_sdr_r   += int'(sdr_a[0] & tck_a[0] & ~prev_tck0);
        n_tdi_sdr += int'(sdr_a[0] & tdi_a[0]);
        n_rv0     += int'(rsp_valid_a[0]);
        if ((uir_a[0] | cdr_a[0] | sdr_a[0] | udr_a[0]) && ir_in_a[0] != 2'b01) n_ir_bad++;
        prev_tck0 = tck_a[0];
        if ((uir_a[1] | cdr_a[1] | sdr_a[1] | udr_a[1]) && prev_scan1) begin
            n1_pairs++;
            if (tck_a[1] == prev_tck1) n1_same++;
        end
        prev_scan1 = uir_a[1] | cdr_a[1] | sdr_a[1] | udr_a[1];
        prev_tck1  = tck_a[1];
    end

    // Present a command and return the index of the accepting edge.
    task automatic send(input int d, input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                        output int acc);
        acc = -1;
        cmd_valid_a[d] = 1'b1;
        cmd_ir_a[d]    = ir;
        cmd_dr_a[d]    = dr;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready_a[d] === 1'b1) begin
                @(posedge clk); #1;
                acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        cmd_valid_a[d] = 1'b0;
        if (acc < 0) chk("accept timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_rsp(input int d, input int acc, output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_a[d] === 1'b1) begin
                lat = cyc - acc;
                break;
            end
        end
    endtask

    int acc, lat;
    int s0, s1, s2, s3, s4, s5, s6, s7, s8;

    initial begin
        for (int d = 0; d < 2; d++) begin
            cmd_valid_a[d] = 1'b0;
            cmd_ir_a[d]    = '0;
            cmd_dr_a[d]    = '0;
            rsp_ready_a[d] = 1'b0;
            loop_a[d]      = 1'b0;
            const_a[d]     = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset cmd_ready", 64'(cmd_ready_a[0]), 64'(1));
        chk("reset rti", 64'(rti_a[0]), 64'(1));
        chk("reset rsp_valid", 64'(rsp_valid_a[0]), 64'(0));
        chk("reset tck", 64'(tck_a[0]), 64'(0));
        reset = 1'b0;

        // Loopback with strobe counting
        loop_a[0] = 1'b1;
        rsp_ready_a[0] = 1'b1;
        s0 = n_uir; s1 = n_uir_r; s2 = n_cdr; s3 = n_cdr_r;
        s4 = n_udr; s5 = n_udr_r; s6 = n_sdr_r; s7 = n_ir_bad;
        send(0, 2'b01, 38'h2A_5A5A_5A5A, acc);
        wait_rsp(0, acc, lat);
        chk("loopback latency", 64'(lat), 64'(165));
        repeat (2) @(posedge clk);
        #1;
        chk("loopback rsp_dr", 64'(rsp_dr_a[0]), 64'(38'h2A_5A5A_5A5A));
        chk("uir cycles", 64'(n_uir - s0), 64'(4));
        chk("uir tck rises", 64'(n_uir_r - s1), 64'(1));
        chk("cdr cycles", 64'(n_cdr - s2), 64'(4));
        chk("cdr tck rises", 64'(n_cdr_r - s3), 64'(1));
        chk("udr cycles", 64'(n_udr - s4), 64'(4));
        chk("udr tck rises", 64'(n_udr_r - s5), 64'(1));
        chk("sdr tck rises", 64'(n_sdr_r - s6), 64'(38));
        chk("ir_in during scan", 64'(n_ir_bad - s7), 64'(0));

        // Constant target: tdo tied high, zero DR
        loop_a[0] = 1'b0;
        const_a[0] = 1'b1;
        s0 = n_tdi_sdr;
        send(0, 2'b10, 38'h0, acc);
        wait_rsp(0, acc, lat);
        chk("const latency", 64'(lat), 64'(165));
        repeat (2) @(posedge clk);
        #1;
        chk("const rsp_dr", 64'(rsp_dr_a[0]), 64'(38'h3F_FFFF_FFFF));
        chk("const tdi in sdr", 64'(n_tdi_sdr - s0), 64'(0));

        // Backpressure with an ignored command pulse
        loop_a[0] = 1'b1;
        const_a[0] = 1'b0;
        rsp_ready_a[0] = 1'b0;
        send(0, 2'b11, 38'h15_A5A5_A5A5, acc);
        wait_rsp(0, acc, lat);
        chk("bp latency", 64'(lat), 64'(165));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                cmd_valid_a[0] = 1'b1;
                cmd_ir_a[0]    = 2'b10;
                cmd_dr_a[0]    = 38'h1;
            end
            if (i == 5) cmd_valid_a[0] = 1'b0;
            @(posedge clk); #1;
            chk("bp cmd_ready", 64'(cmd_ready_a[0]), 64'(0));
            chk("bp rsp_valid", 64'(rsp_valid_a[0]), 64'(1));
            chk("bp rsp_dr", 64'(rsp_dr_a[0]), 64'(38'h15_A5A5_A5A5));
        end
        chk("bp ir_in kept", 64'(ir_in_a[0]), 64'(2'b11));
        rsp_ready_a[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_a[0] = 1'b0;
        chk("bp release rsp_valid", 64'(rsp_valid_a[0]), 64'(0));
        chk("bp release cmd_ready +1", 64'(cmd_ready_a[0]), 64'(0));
        @(posedge clk); #1;
        chk("bp release cmd_ready +2", 64'(cmd_ready_a[0]), 64'(1));

        // Reset in the middle of SDR at bit 17
        rsp_ready_a[0] = 1'b1;
        send(0, 2'b10, 38'h3F_0F0F_1234, acc);
        repeat (77) @(posedge clk);
        #1;
        chk("at bit 17 in sdr", 64'(sdr_a[0]), 64'(1));
        s0 = n_udr; s1 = n_rv0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid reset outputs",
            64'({cmd_ready_a[0], rti_a[0], rsp_valid_a[0], tck_a[0], tdi_a[0],
                 uir_a[0], cdr_a[0], sdr_a[0], udr_a[0]}), 64'(9'b110000000));
        chk("mid reset ir_in", 64'(ir_in_a[0]), 64'(0));
        chk("mid reset rsp_dr", 64'(rsp_dr_a[0]), 64'(0));
        repeat (200) @(posedge clk);
        #1;
        chk("no udr after reset", 64'(n_udr - s0), 64'(0));
        chk("no rsp after reset", 64'(n_rv0 - s1), 64'(0));
        send(0, 2'b01, 38'h0C_3C3C_C3C3, acc);
        wait_rsp(0, acc, lat);
        chk("post reset latency", 64'(lat), 64'(165));
        repeat (2) @(posedge clk);
        #1;
        chk("post reset rsp_dr", 64'(rsp_dr_a[0]), 64'(38'h0C_3C3C_C3C3));

        // TCK_HALF=1 loopback
        loop_a[1] = 1'b1;
        rsp_ready_a[1] = 1'b1;
        s8 = n1_pairs; s7 = n1_same;
        send(1, 2'b01, 38'h2A_5A5A_5A5A, acc);
        wait_rsp(1, acc, lat);
        chk("half1 latency", 64'(lat), 64'(83));
        repeat (2) @(posedge clk);
        #1;
        chk("half1 rsp_dr", 64'(rsp_dr_a[1]), 64'(38'h2A_5A5A_5A5A));
        chk("half1 scan pairs", 64'(n1_pairs - s8), 64'(81));
        chk("half1 tck stalls", 64'(n1_same - s7), 64'(0));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
